mult_div: RTL



---
 rtl/mult_div_if.sv | 25 ++
 rtl/mult_div.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mult_div_if.sv
// Request/response bundle between pipeline control and the mult_div unit.
interface mult_div_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, mthi, mtlo,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div.sv
// Iterative radix-2 multiply/divide unit holding architectural HI/LO.
// Operands are latched as magnitudes; signs are re-applied in FIX.
// Optional macro MULDIV_TRACE_EN: prints a line per completed operation
// and per HI/LO move (simulation only, no effect on results).
module mult_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  mult_div_if.slave bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned ACC_W = WIDTH + 1;
  localparam int unsigned PRD_W = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;     // partial product high half / partial remainder
  logic [WIDTH-1:0]   mq_q, mq_d;       // multiplier bits / dividend-then-quotient
  logic [WIDTH-1:0]   opd_q, opd_d;     // |multiplicand| or |divisor|
  logic               div_q, div_d;
  logic               neg_q, neg_d;     // negate product or quotient
  logic               rneg_q, rneg_d;   // negate remainder (dividend sign)
  logic               dz_q, dz_d;       // divide by zero
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [ACC_W-1:0]   sum, rem_sh, diff;
  logic [PRD_W-1:0]   prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      opd_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      opd_q   <= opd_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, iteration step and result fix-up
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    opd_d   = opd_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // op[0]=1 selects the unsigned variants
    a_neg   = ~bus.op[0] & bus.a[WIDTH-1];
    b_neg   = ~bus.op[0] & bus.b[WIDTH-1];
    a_abs   = a_neg ? (~bus.a + WIDTH'(1)) : bus.a;
    b_abs   = b_neg ? (~bus.b + WIDTH'(1)) : bus.b;

    sum      = acc_q + (mq_q[0] ? {1'b0, opd_q} : ACC_W'(0));
    rem_sh   = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
    diff     = rem_sh - {1'b0, opd_q};
    prod     = {acc_q[WIDTH-1:0], mq_q};
    prod_fix = neg_q ? (~prod + PRD_W'(1)) : prod;
    quo_fix  = neg_q ? (~mq_q + WIDTH'(1)) : mq_q;
    rem_fix  = rneg_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
          cnt_d   = '0;
          acc_d   = '0;
          div_d   = bus.op[1];
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          dz_d    = bus.op[1] & (bus.b == '0);
          opd_d   = bus.op[1] ? b_abs : a_abs;
          mq_d    = bus.op[1] ? a_abs : b_abs;
        end else begin
          if (bus.mthi) hi_d = bus.a;
          if (bus.mtlo) lo_d = bus.a;
        end
      end
      S_RUN: begin
        if (div_q) begin
          // restoring step: keep the subtraction only when it did not borrow
          if (!diff[WIDTH]) begin
            acc_d = diff;
            mq_d  = {mq_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = rem_sh;
            mq_d  = {mq_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = {1'b0, sum[WIDTH:1]};
          mq_d  = {sum[0], mq_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (div_q) begin
          // a zero divisor leaves |a| as remainder, so rem_fix restores a
          lo_d = dz_q ? {WIDTH{1'b1}} : quo_fix;
          hi_d = rem_fix;
        end else begin
          hi_d = prod_fix[PRD_W-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

`ifdef MULDIV_TRACE_EN
  logic [1:0]       trc_op_q;
  logic [WIDTH-1:0] trc_a_q, trc_b_q;

  // Simulation trace of completed operations and HI/LO moves
  always_ff @(posedge clk) begin
    if (rst_n && state_q == S_IDLE && bus.start) begin
      trc_op_q <= bus.op;
      trc_a_q  <= bus.a;
      trc_b_q  <= bus.b;
    end
    if (rst_n && state_q == S_FIX)
      $display("%0t mult_div op=%0d a=%h b=%h => hi=%h lo=%h",
               $time, trc_op_q, trc_a_q, trc_b_q, hi_d, lo_d);
    if (rst_n && state_q == S_IDLE && !bus.start && (bus.mthi || bus.mtlo))
      $display("%0t mult_div HI/LO <= %h", $time, bus.a);
  end
`endif

endmodule
